// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave Wishbone round-robin arbiter. Ownership spans a whole cyc
// envelope; a watchdog returns err to the owner when the slave stops acking.
module wb_rr_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam bit          WD_EN   = (TIMEOUT != 0);
    localparam logic [15:0] WD_LAST = WD_EN ? 16'(TIMEOUT - 1) : 16'd0;

    state_t      state;
    state_t      state_next;
    logic        last;
    logic        last_next;
    logic [15:0] wd;
    logic [15:0] wd_next;

    logic [31:0] own_adr;
    logic [31:0] own_dat;
    logic [3:0]  own_sel;
    logic        own_we;
    logic        own_cyc;
    logic        own_stb;
    logic        expire;

    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state)
            OWN0: begin
                own_adr = m0_adr_i;
                own_dat = m0_dat_i;
                own_sel = m0_sel_i;
                own_we  = m0_we_i;
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
            end
            OWN1: begin
                own_adr = m1_adr_i;
                own_dat = m1_dat_i;
                own_sel = m1_sel_i;
                own_we  = m1_we_i;
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

    // An ack arriving in the expiry cycle wins, so expiry needs s_ack_i low.
    assign expire = WD_EN && own_stb && !s_ack_i && (wd == WD_LAST);

    assign s_adr_o = own_adr;
    assign s_dat_o = own_dat;
    assign s_sel_o = own_sel;
    assign s_we_o  = own_we;
    assign s_cyc_o = own_cyc && !expire;
    assign s_stb_o = own_stb && !expire;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = (state == OWN0) && s_ack_i;
    assign m1_ack_o = (state == OWN1) && s_ack_i;
    assign m0_err_o = (state == OWN0) && expire;
    assign m1_err_o = (state == OWN1) && expire;
    assign gnt_o    = {state == OWN1, state == OWN0};

    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_next = OWN0;
                end else if (m1_cyc_i) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    last_next  = 1'b0;
                    state_next = m1_cyc_i ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    last_next  = 1'b1;
                    state_next = m0_cyc_i ? OWN0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wd_next = wd + 16'd1;
        if (!WD_EN || (state_next != state) || s_ack_i || !own_stb || expire) begin
            wd_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            wd    <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            wd    <= wd_next;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: one instance with an 8-cycle watchdog, one with it disabled,
// both driven by the same masters and checked every cycle against a behavioural model.
module tb_wb_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] adr   [2];
    logic [31:0] dat_w [2];
    logic [3:0]  sel   [2];
    logic        we    [2];
    logic        cyc   [2];
    logic        stb   [2];
    logic        s_ack;
    logic [31:0] s_dat;

    logic [31:0] s_adr  [2];
    logic [31:0] s_dato [2];
    logic [3:0]  s_sel  [2];
    logic        s_we   [2];
    logic        s_cyc  [2];
    logic        s_stb  [2];
    logic [1:0]  gnt    [2];
    logic [31:0] mdat   [2][2];
    logic        ack    [2][2];
    logic        err    [2][2];

    int total = 0;
    int bad   = 0;

    int to_val [2] = '{8, 0};

    always #5 clk = ~clk;

    wb_rr_arbiter #(.TIMEOUT(8)) dut_wd (
        .clk(clk), .rst(rst),
        .m0_adr_i(adr[0]), .m0_dat_i(dat_w[0]), .m0_dat_o(mdat[0][0]), .m0_sel_i(sel[0]),
        .m0_we_i(we[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_ack_o(ack[0][0]), .m0_err_o(err[0][0]),
        .m1_adr_i(adr[1]), .m1_dat_i(dat_w[1]), .m1_dat_o(mdat[0][1]), .m1_sel_i(sel[1]),
        .m1_we_i(we[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_ack_o(ack[0][1]), .m1_err_o(err[0][1]),
        .s_adr_o(s_adr[0]), .s_dat_o(s_dato[0]), .s_sel_o(s_sel[0]), .s_we_o(s_we[0]),
        .s_cyc_o(s_cyc[0]), .s_stb_o(s_stb[0]), .s_ack_i(s_ack), .s_dat_i(s_dat), .gnt_o(gnt[0])
    );

    wb_rr_arbiter #(.TIMEOUT(0)) dut_nowd (
        .clk(clk), .rst(rst),
        .m0_adr_i(adr[0]), .m0_dat_i(dat_w[0]), .m0_dat_o(mdat[1][0]), .m0_sel_i(sel[0]),
        .m0_we_i(we[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_ack_o(ack[1][0]), .m0_err_o(err[1][0]),
        .m1_adr_i(adr[1]), .m1_dat_i(dat_w[1]), .m1_dat_o(mdat[1][1]), .m1_sel_i(sel[1]),
        .m1_we_i(we[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_ack_o(ack[1][1]), .m1_err_o(err[1][1]),
        .s_adr_o(s_adr[1]), .s_dat_o(s_dato[1]), .s_sel_o(s_sel[1]), .s_we_o(s_we[1]),
        .s_cyc_o(s_cyc[1]), .s_stb_o(s_stb[1]), .s_ack_i(s_ack), .s_dat_i(s_dat), .gnt_o(gnt[1])
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int m, input logic c, input logic s);
        cyc[m] = c;
        stb[m] = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: owner (-1 idle), last served master, and per instance the count of
    // consecutive unanswered strobe cycles since the grant or the last err.
    int own      = -1;
    int last_srv = 1;
    int stall [2] = '{0, 0};
    bit fire  [2];
    int nown;
    int o;
    logic [1:0] e_gnt;

    initial begin : model
        forever begin
            @(negedge clk);
            if (!rst) begin
                own      = -1;
                last_srv = 1;
                stall[0] = 0;
                stall[1] = 0;
            end
            o     = (own < 0) ? 0 : own;
            e_gnt = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
            for (int i = 0; i < 2; i++) begin
                fire[i] = (own >= 0) && (to_val[i] != 0) && stb[o] && !s_ack && (stall[i] == to_val[i] - 1);
                check_output($sformatf("i%0d gnt", i), 32'(gnt[i]), 32'(e_gnt));
                check_output($sformatf("i%0d s_adr", i), s_adr[i], (own >= 0) ? adr[o] : 32'h0);
                check_output($sformatf("i%0d s_dat", i), s_dato[i], (own >= 0) ? dat_w[o] : 32'h0);
                check_output($sformatf("i%0d s_sel", i), 32'(s_sel[i]), (own >= 0) ? 32'(sel[o]) : 32'h0);
                check_output($sformatf("i%0d s_we", i), 32'(s_we[i]), 32'((own >= 0) && we[o]));
                check_output($sformatf("i%0d s_cyc", i), 32'(s_cyc[i]), 32'((own >= 0) && cyc[o] && !fire[i]));
                check_output($sformatf("i%0d s_stb", i), 32'(s_stb[i]), 32'((own >= 0) && stb[o] && !fire[i]));
                for (int m = 0; m < 2; m++) begin
                    check_output($sformatf("i%0d m%0d dat", i, m), mdat[i][m], s_dat);
                    check_output($sformatf("i%0d m%0d ack", i, m), 32'(ack[i][m]), 32'((own == m) && s_ack));
                    check_output($sformatf("i%0d m%0d err", i, m), 32'(err[i][m]), 32'((own == m) && fire[i]));
                end
            end
            if (rst) begin
                nown = own;
                if (own < 0) begin
                    if (cyc[0] && cyc[1]) nown = 1 - last_srv;
                    else if (cyc[0]) nown = 0;
                    else if (cyc[1]) nown = 1;
                end else if (!cyc[own]) begin
                    last_srv = own;
                    nown     = cyc[1 - own] ? 1 - own : -1;
                end
                for (int i = 0; i < 2; i++) begin
                    if (own < 0 || nown != own || fire[i] || s_ack || !stb[o]) stall[i] = 0;
                    else stall[i] = stall[i] + 1;
                end
                own = nown;
            end
        end
    end

    int cur;
    int errs_a;
    int errs_b;
    int drops_b;

    initial begin : stimulus
        adr[0]   = 32'h0000_1000;  adr[1]   = 32'h0000_2000;
        dat_w[0] = 32'h0D0D_0000;  dat_w[1] = 32'h1D1D_0001;
        sel[0]   = 4'h3;           sel[1]   = 4'hC;
        we[0]    = 1'b0;           we[1]    = 1'b1;
        cyc[0] = 1'b0; cyc[1] = 1'b0; stb[0] = 1'b0; stb[1] = 1'b0;
        s_ack = 1'b0;
        s_dat = 32'h0;
        #2 rst = 1'b0;

        // Reset priority: both request on the release edge, master 0 wins
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        apply_stimulus(0, 1'b1, 1'b1);
        apply_stimulus(1, 1'b1, 1'b1);
        step();
        @(negedge clk);
        check_output("reset gnt", 32'(gnt[0]), 32'h1);
        check_output("reset m1 ack", 32'(ack[0][1]), 32'h0);
        step();
        s_ack = 1'b1;
        s_dat = 32'hDEAD_BEEF;
        @(negedge clk);
        check_output("reset m0 ack", 32'(ack[0][0]), 32'h1);
        check_output("reset m0 rdata", mdat[0][0], 32'hDEAD_BEEF);
        check_output("reset m1 ack beat", 32'(ack[0][1]), 32'h0);
        step();
        s_ack = 1'b0;
        apply_stimulus(0, 1'b0, 1'b0);
        step();
        s_ack = 1'b1;
        s_dat = 32'h0000_1111;
        @(negedge clk);
        check_output("follow gnt", 32'(gnt[0]), 32'h2);
        check_output("follow we", 32'(s_we[0]), 32'h1);
        step();
        s_ack = 1'b0;
        apply_stimulus(1, 1'b0, 1'b0);
        step();

        // Round-robin: one beat per envelope, grants must alternate
        apply_stimulus(0, 1'b1, 1'b1);
        apply_stimulus(1, 1'b1, 1'b1);
        cur = 0;
        for (int g = 0; g < 8; g++) begin
            step();
            if (g > 0) apply_stimulus(1 - cur, 1'b1, 1'b1);
            s_ack = 1'b1;
            s_dat = 32'hA000_0000 + 32'(g);
            @(negedge clk);
            check_output($sformatf("rr gnt %0d", g), 32'(gnt[0]), (g % 2 == 0) ? 32'h1 : 32'h2);
            check_output($sformatf("rr idle ack %0d", g), 32'(ack[0][1 - cur]), 32'h0);
            step();
            s_ack = 1'b0;
            apply_stimulus(cur, 1'b0, 1'b0);
            if (g == 7) apply_stimulus(1 - cur, 1'b0, 1'b0);
            cur = 1 - cur;
        end
        step();

        // Hand-over: 4-beat burst on master 0 while master 1 waits
        adr[1] = 32'h0000_4000;
        apply_stimulus(0, 1'b1, 1'b1);
        apply_stimulus(1, 1'b1, 1'b1);
        for (int b = 0; b < 4; b++) begin
            step();
            adr[0] = 32'h0000_3000 + 32'(4 * b);
            s_ack  = 1'b1;
            @(negedge clk);
            check_output($sformatf("burst gnt %0d", b), 32'(gnt[0]), 32'h1);
            check_output($sformatf("burst adr %0d", b), s_adr[0], 32'h0000_3000 + 32'(4 * b));
            check_output($sformatf("burst m1 ack %0d", b), 32'(ack[0][1]), 32'h0);
        end
        step();
        s_ack = 1'b0;
        apply_stimulus(0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("drop cycle gnt", 32'(gnt[0]), 32'h1);
        check_output("drop cycle stb", 32'(s_stb[0]), 32'h0);
        step();
        @(negedge clk);
        check_output("handover gnt", 32'(gnt[0]), 32'h2);
        check_output("handover adr", s_adr[0], 32'h0000_4000);
        step();
        apply_stimulus(1, 1'b0, 1'b0);
        step();

        // Watchdog expiry, then the ack-collision variant
        adr[0] = 32'h0000_5000;
        apply_stimulus(0, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            @(negedge clk);
            check_output($sformatf("wd err %0d", k), 32'(err[0][0]), 32'(k == 8));
            check_output($sformatf("wd stb %0d", k), 32'(s_stb[0]), 32'(k != 8));
            check_output($sformatf("wd cyc %0d", k), 32'(s_cyc[0]), 32'(k != 8));
            check_output($sformatf("nowd stb %0d", k), 32'(s_stb[1]), 32'h1);
        end
        step();
        apply_stimulus(0, 1'b0, 1'b0);
        step();
        apply_stimulus(0, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 8) s_ack = 1'b1;
            @(negedge clk);
            check_output($sformatf("coll err %0d", k), 32'(err[0][0]), 32'h0);
            check_output($sformatf("coll ack %0d", k), 32'(ack[0][0]), 32'(k == 8));
        end
        step();
        s_ack = 1'b0;
        apply_stimulus(0, 1'b0, 1'b0);
        step();

        // Long stall: only the watchdog instance may raise err
        errs_a  = 0;
        errs_b  = 0;
        drops_b = 0;
        apply_stimulus(0, 1'b1, 1'b1);
        for (int k = 1; k <= 1000; k++) begin
            step();
            @(negedge clk);
            if (err[0][0]) errs_a++;
            if (err[1][0]) errs_b++;
            if (!s_stb[1]) drops_b++;
        end
        check_output("stall errs wd", 32'(errs_a), 32'd125);
        check_output("stall errs nowd", 32'(errs_b), 32'd0);
        check_output("stall stb drops nowd", 32'(drops_b), 32'd0);
        step();
        apply_stimulus(0, 1'b0, 1'b0);
        step();

        // Asynchronous reset in the middle of a master 1 transfer
        adr[1] = 32'h0000_6000;
        apply_stimulus(1, 1'b1, 1'b1);
        step();
        s_ack = 1'b1;
        s_dat = 32'h1234_5678;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("areset gnt", 32'(gnt[0]), 32'h0);
        check_output("areset stb", 32'(s_stb[0]), 32'h0);
        check_output("areset cyc", 32'(s_cyc[0]), 32'h0);
        check_output("areset adr", s_adr[0], 32'h0);
        check_output("areset m1 ack", 32'(ack[0][1]), 32'h0);
        check_output("areset m1 rdata", mdat[0][1], 32'h1234_5678);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        s_ack = 1'b0;
        apply_stimulus(0, 1'b1, 1'b1);
        step();
        @(negedge clk);
        check_output("post reset gnt", 32'(gnt[0]), 32'h1);
        check_output("post reset gnt nowd", 32'(gnt[1]), 32'h1);
        step();
        apply_stimulus(0, 1'b0, 1'b0);
        apply_stimulus(1, 1'b0, 1'b0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
